// File: rtl/trigger_chain_core.sv
// trigger_chain_core
//
// Purpose:
//   Two cascaded programmable notch-filter stages on an 8-sample-per-clock,
//   12-bit signed ADC stream. Each stage computes
//     y[n] = sat12((B*x[n] + A*x[n-1] + B*x[n-2]) >>> 14)
//   with Q4.14 coefficients. Coefficients are written over a Wishbone slave
//   into shadow registers and made live by an update strobe. Stage 0 output
//   is exported on the probe bus, stage 1 output is the chain output.
//
// Ports:
//   wb_clk_i              sole clock (Wishbone and sample stream)
//   wb_rst_i              synchronous active-high reset, clears everything
//   wb_cyc_i/stb_i/we_i   Wishbone cycle, strobe, write enable
//   wb_sel_i              ignored, only full 32-bit writes are supported
//   wb_adr_i[7:0]         [7] stage select, [6:0] register offset
//   wb_dat_i[31:0]        write data, coefficients taken from [17:0]
//   wb_ack_o              one-cycle acknowledge per request
//   wb_dat_o              read data, always 0
//   wb_err_o/rty_o        tied 0
//   reset_BQ_i            synchronous clear of filter history and pipeline
//   dat_i[95:0]           input samples, lane i at [12i +: 12], lane 0 oldest
//   dat_o[95:0]           stage-1 output (4 clocks after dat_i)
//   probes[95:0]          stage-0 output (2 clocks after dat_i)
//
// Configuration:
//   TRIGGER_CHAIN_PROBE_EN  defined: probes carries the registered stage-0
//                           output; undefined: probes is tied to 0.

module trigger_chain_core (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        wb_cyc_i,
  input  logic        wb_stb_i,
  input  logic        wb_we_i,
  input  logic [3:0]  wb_sel_i,
  input  logic [7:0]  wb_adr_i,
  input  logic [31:0] wb_dat_i,
  output logic        wb_ack_o,
  output logic [31:0] wb_dat_o,
  output logic        wb_err_o,
  output logic        wb_rty_o,
  input  logic        reset_BQ_i,
  input  logic [95:0] dat_i,
  output logic [95:0] dat_o,
  output logic [95:0] probes
);

  localparam int NSAMP      = 8;
  localparam int NBITS      = 12;
  localparam int COEFF_BITS = 18;
  localparam int FRAC_BITS  = 14;
  localparam int NSTAGE     = 2;
  localparam int PROD_BITS  = COEFF_BITS + NBITS;
  localparam int SUM_BITS   = 32;

  localparam logic signed [COEFF_BITS-1:0] COEFF_ONE = 18'sd16384;
  localparam logic signed [SUM_BITS-1:0]   SAT_MAX   = 32'sd2047;
  localparam logic signed [SUM_BITS-1:0]   SAT_MIN   = -32'sd2048;

  // Wishbone handshake and decode
  logic                         r_ack;
  logic                         w_wr;
  logic                         w_stage;
  logic [6:0]                   w_off;
  logic signed [COEFF_BITS-1:0] w_wdat;

  // Coefficient storage: shadow and live copies of B and A per stage
  logic signed [COEFF_BITS-1:0] r_shB  [NSTAGE];
  logic signed [COEFF_BITS-1:0] r_shA  [NSTAGE];
  logic signed [COEFF_BITS-1:0] r_actB [NSTAGE];
  logic signed [COEFF_BITS-1:0] r_actA [NSTAGE];

  // Per-offset slot pointers
  logic       r_ptr04 [NSTAGE];
  logic [1:0] r_ptr08 [NSTAGE];
  logic       r_ptr0C [NSTAGE];
  logic [2:0] r_ptr10 [NSTAGE];
  logic [2:0] r_ptr14 [NSTAGE];

  // Pole-section coefficients: stored only, no datapath uses them yet
  logic [COEFF_BITS-1:0] r_slot08 [NSTAGE][4];
  logic [COEFF_BITS-1:0] r_slot0C [NSTAGE][2];
  logic [COEFF_BITS-1:0] r_slot10 [NSTAGE][7];
  logic [COEFF_BITS-1:0] r_slot14 [NSTAGE][8];
  logic [COEFF_BITS-1:0] r_slot18 [NSTAGE];
  logic [COEFF_BITS-1:0] r_slot1C [NSTAGE];

  logic w_unused_fold;

  assign w_wr     = wb_cyc_i & wb_stb_i & wb_we_i & ~r_ack;
  assign w_stage  = wb_adr_i[7];
  assign w_off    = wb_adr_i[6:0];
  assign w_wdat   = wb_dat_i[COEFF_BITS-1:0];

  assign wb_ack_o = r_ack;
  assign wb_dat_o = '0;
  assign wb_err_o = 1'b0;
  assign wb_rty_o = 1'b0;

  // Register file. The ~ack term makes a held request alternate, so a
  // master that drops stb on ack sees exactly one ack and one write.
  // An update copies the shadow pair into the live pair and rewinds all
  // of that stage's slot pointers; reset takes priority over an update.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_ack <= 1'b0;
      for (int s = 0; s < NSTAGE; s++) begin
        r_shB[s]   <= '0;
        r_shA[s]   <= COEFF_ONE;
        r_actB[s]  <= '0;
        r_actA[s]  <= COEFF_ONE;
        r_ptr04[s] <= 1'b0;
        r_ptr08[s] <= '0;
        r_ptr0C[s] <= 1'b0;
        r_ptr10[s] <= '0;
        r_ptr14[s] <= '0;
        r_slot18[s] <= '0;
        r_slot1C[s] <= '0;
        for (int k = 0; k < 4; k++) r_slot08[s][k] <= '0;
        for (int k = 0; k < 2; k++) r_slot0C[s][k] <= '0;
        for (int k = 0; k < 7; k++) r_slot10[s][k] <= '0;
        for (int k = 0; k < 8; k++) r_slot14[s][k] <= '0;
      end
    end else begin
      r_ack <= wb_cyc_i & wb_stb_i & ~r_ack;
      if (w_wr) begin
        case (w_off)
          7'h00: begin
            if (wb_dat_i[0]) begin
              r_actB[w_stage]  <= r_shB[w_stage];
              r_actA[w_stage]  <= r_shA[w_stage];
              r_ptr04[w_stage] <= 1'b0;
              r_ptr08[w_stage] <= '0;
              r_ptr0C[w_stage] <= 1'b0;
              r_ptr10[w_stage] <= '0;
              r_ptr14[w_stage] <= '0;
            end
          end
          7'h04: begin
            if (r_ptr04[w_stage] == 1'b0) r_shB[w_stage] <= w_wdat;
            else                          r_shA[w_stage] <= w_wdat;
            r_ptr04[w_stage] <= ~r_ptr04[w_stage];
          end
          7'h08: begin
            r_slot08[w_stage][r_ptr08[w_stage]] <= w_wdat;
            r_ptr08[w_stage] <= r_ptr08[w_stage] + 2'd1;
          end
          7'h0C: begin
            r_slot0C[w_stage][r_ptr0C[w_stage]] <= w_wdat;
            r_ptr0C[w_stage] <= ~r_ptr0C[w_stage];
          end
          7'h10: begin
            r_slot10[w_stage][r_ptr10[w_stage]] <= w_wdat;
            r_ptr10[w_stage] <= (r_ptr10[w_stage] == 3'd6) ? 3'd0 : r_ptr10[w_stage] + 3'd1;
          end
          7'h14: begin
            r_slot14[w_stage][r_ptr14[w_stage]] <= w_wdat;
            r_ptr14[w_stage] <= r_ptr14[w_stage] + 3'd1;
          end
          7'h18:   r_slot18[w_stage] <= w_wdat;
          7'h1C:   r_slot1C[w_stage] <= w_wdat;
          default: ;
        endcase
      end
    end
  end

  // Reserved coefficients and ignored inputs are folded into one sink so
  // they stay in the design without driving anything.
  always_comb begin
    w_unused_fold = ^{wb_sel_i, wb_dat_i[31:COEFF_BITS]};
    for (int s = 0; s < NSTAGE; s++) begin
      w_unused_fold = w_unused_fold ^ (^r_slot18[s]) ^ (^r_slot1C[s]);
      for (int k = 0; k < 4; k++) w_unused_fold = w_unused_fold ^ (^r_slot08[s][k]);
      for (int k = 0; k < 2; k++) w_unused_fold = w_unused_fold ^ (^r_slot0C[s][k]);
      for (int k = 0; k < 7; k++) w_unused_fold = w_unused_fold ^ (^r_slot10[s][k]);
      for (int k = 0; k < 8; k++) w_unused_fold = w_unused_fold ^ (^r_slot14[s][k]);
    end
  end

  logic [NSTAGE-1:0][NSAMP*NBITS-1:0] w_stageOut;

  for (genvar gs = 0; gs < NSTAGE; gs++) begin : g_stage
    logic [NSAMP*NBITS-1:0]     w_in;
    logic [(NSAMP+2)*NBITS-1:0] w_ext;
    logic signed [NBITS-1:0]    r_hist6;
    logic signed [NBITS-1:0]    r_hist7;
    logic signed [PROD_BITS-1:0] r_pCur   [NSAMP];
    logic signed [PROD_BITS-1:0] r_pPrev1 [NSAMP];
    logic signed [PROD_BITS-1:0] r_pPrev2 [NSAMP];
    logic signed [SUM_BITS-1:0]  w_sum    [NSAMP];
    logic signed [SUM_BITS-1:0]  w_shr    [NSAMP];
    logic [NSAMP*NBITS-1:0]     w_sat;
    logic [NSAMP*NBITS-1:0]     r_y;

    if (gs == 0) begin : g_src_adc
      assign w_in = dat_i;
    end else begin : g_src_prev
      assign w_in = w_stageOut[gs-1];
    end

    // Lane j of w_ext is sample n-2+j relative to lane 0, so the last two
    // samples of the previous clock sit below lane 0 of this clock.
    assign w_ext = {w_in, r_hist7, r_hist6};

    // Product register: one B*x[n], A*x[n-1], B*x[n-2] triple per lane.
    always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i || reset_BQ_i) begin
        r_hist6 <= '0;
        r_hist7 <= '0;
        for (int i = 0; i < NSAMP; i++) begin
          r_pCur[i]   <= '0;
          r_pPrev1[i] <= '0;
          r_pPrev2[i] <= '0;
        end
      end else begin
        r_hist6 <= w_in[6*NBITS +: NBITS];
        r_hist7 <= w_in[7*NBITS +: NBITS];
        for (int i = 0; i < NSAMP; i++) begin
          r_pCur[i]   <= PROD_BITS'(r_actB[gs]) * PROD_BITS'($signed(w_ext[(i+2)*NBITS +: NBITS]));
          r_pPrev1[i] <= PROD_BITS'(r_actA[gs]) * PROD_BITS'($signed(w_ext[(i+1)*NBITS +: NBITS]));
          r_pPrev2[i] <= PROD_BITS'(r_actB[gs]) * PROD_BITS'($signed(w_ext[i*NBITS +: NBITS]));
        end
      end
    end

    // Sum, arithmetic truncating shift back to integer, clamp to 12 bits.
    always_comb begin
      w_sat = '0;
      for (int i = 0; i < NSAMP; i++) begin
        w_sum[i] = SUM_BITS'(r_pCur[i]) + SUM_BITS'(r_pPrev1[i]) + SUM_BITS'(r_pPrev2[i]);
        w_shr[i] = w_sum[i] >>> FRAC_BITS;
        if (w_shr[i] > SAT_MAX)      w_sat[i*NBITS +: NBITS] = 12'h7FF;
        else if (w_shr[i] < SAT_MIN) w_sat[i*NBITS +: NBITS] = 12'h800;
        else                         w_sat[i*NBITS +: NBITS] = w_shr[i][NBITS-1:0];
      end
    end

    // Output register of the stage.
    always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i || reset_BQ_i) r_y <= '0;
      else                        r_y <= w_sat;
    end

    assign w_stageOut[gs] = r_y;
  end

  assign dat_o = w_stageOut[NSTAGE-1];

`ifdef TRIGGER_CHAIN_PROBE_EN
  assign probes = w_stageOut[0];
`else
  assign probes = '0;
`endif

endmodule

// File: tb/tb_trigger_chain_core.sv
// Self-checking bench for trigger_chain_core. Vectors carry the input
// samples plus the stage-0 and stage-1 responses to that input; expected
// values are queued when a vector is driven and compared when the DUT
// latency has elapsed. Probe expectations become 0 when the probe bus is
// compiled out.

module tb_trigger_chain_core;

  logic        clk = 1'b0;
  logic        rst;
  logic        cyc, stb, we;
  logic [3:0]  sel;
  logic [7:0]  adr;
  logic [31:0] wdat;
  logic        ack;
  logic [31:0] rdat;
  logic        err, rty;
  logic        rstBQ;
  logic [95:0] din;
  logic [95:0] dout;
  logic [95:0] prb;

  always #5 clk = ~clk;

  trigger_chain_core dut (
    .wb_clk_i   (clk),
    .wb_rst_i   (rst),
    .wb_cyc_i   (cyc),
    .wb_stb_i   (stb),
    .wb_we_i    (we),
    .wb_sel_i   (sel),
    .wb_adr_i   (adr),
    .wb_dat_i   (wdat),
    .wb_ack_o   (ack),
    .wb_dat_o   (rdat),
    .wb_err_o   (err),
    .wb_rty_o   (rty),
    .reset_BQ_i (rstBQ),
    .dat_i      (din),
    .dat_o      (dout),
    .probes     (prb)
  );

  typedef struct {
    int          phase;
    int          id;
    logic [95:0] din;
    logic [95:0] expProbe;
    logic [95:0] expDout;
  } vec_t;

  typedef struct {
    int          due;
    int          id;
    logic [95:0] exp;
  } sb_t;

  localparam logic [95:0] Z = '0;

  vec_t tbl[$];
  sb_t  probeQ[$];
  sb_t  doutQ[$];
  sb_t  monEntry;
  int   cycleCount = 0;
  int   totalChecks = 0;
  int   badChecks = 0;

  always @(posedge clk) cycleCount <= cycleCount + 1;

  function automatic logic [95:0] setLane(logic [95:0] base, int idx, int val);
    logic [95:0] r;
    r = base;
    r[idx*12 +: 12] = 12'(val);
    return r;
  endfunction

  function automatic logic [95:0] allLanes(int val);
    logic [95:0] r;
    r = '0;
    for (int i = 0; i < 8; i++) r[i*12 +: 12] = 12'(val);
    return r;
  endfunction

  task automatic checkOutput(input string name, input logic [95:0] actual, input logic [95:0] expected);
    totalChecks++;
    if (actual !== expected) begin
      badChecks++;
      $display("[TB] FAIL %s: actual=%h expected=%h", name, actual, expected);
    end
  endtask

  task automatic addVec(input int phase, input logic [95:0] d, input logic [95:0] p, input logic [95:0] o);
    vec_t v;
    v.phase = phase;
    v.id = tbl.size();
    v.din = d;
    v.expProbe = p;
    v.expDout = o;
    tbl.push_back(v);
  endtask

  task automatic applyStimulus(input vec_t v);
    sb_t e;
    @(posedge clk);
    #1;
    din = v.din;
    e.id = v.id;
    e.due = cycleCount + 2;
`ifdef TRIGGER_CHAIN_PROBE_EN
    e.exp = v.expProbe;
`else
    e.exp = '0;
`endif
    probeQ.push_back(e);
    e.due = cycleCount + 4;
    e.exp = v.expDout;
    doutQ.push_back(e);
  endtask

  // Scoreboard monitor, samples on the falling edge.
  always @(negedge clk) begin
    while (probeQ.size() > 0 && probeQ[0].due <= cycleCount) begin
      monEntry = probeQ.pop_front();
      if (monEntry.due < cycleCount) checkOutput($sformatf("vec%0d probes late", monEntry.id), 96'd1, 96'd0);
      else checkOutput($sformatf("vec%0d probes", monEntry.id), prb, monEntry.exp);
    end
    while (doutQ.size() > 0 && doutQ[0].due <= cycleCount) begin
      monEntry = doutQ.pop_front();
      if (monEntry.due < cycleCount) checkOutput($sformatf("vec%0d dat_o late", monEntry.id), 96'd1, 96'd0);
      else checkOutput($sformatf("vec%0d dat_o", monEntry.id), dout, monEntry.exp);
    end
  end

  task automatic runPhase(input int p);
    for (int i = 0; i < tbl.size(); i++)
      if (tbl[i].phase == p) applyStimulus(tbl[i]);
    for (int k = 0; k < 6; k++) begin
      @(posedge clk);
      #1;
      din = '0;
    end
    @(negedge clk);
    checkOutput($sformatf("phase%0d probe drain", p), 96'(probeQ.size()), 96'd0);
    checkOutput($sformatf("phase%0d dout drain", p), 96'(doutQ.size()), 96'd0);
  endtask

  task automatic wbWrite(input logic [7:0] a, input logic [31:0] d);
    bit got;
    @(posedge clk);
    #1;
    cyc = 1'b1;
    stb = 1'b1;
    we = 1'b1;
    adr = a;
    wdat = d;
    got = 1'b0;
    for (int k = 0; k < 8 && !got; k++) begin
      @(negedge clk);
      if (ack) got = 1'b1;
    end
    cyc = 1'b0;
    stb = 1'b0;
    we = 1'b0;
    checkOutput($sformatf("ack adr %h", a), 96'(got), 96'd1);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: run did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int pulses;

    rst = 1'b1; cyc = 1'b0; stb = 1'b0; we = 1'b0; sel = 4'hF;
    adr = '0; wdat = '0; rstBQ = 1'b0; din = '0;

    // Vector table: {phase, din, stage-0 response, stage-1 response}
    addVec(0, Z, Z, Z);
    addVec(0, setLane(Z, 0, 512), setLane(Z, 1, 512), setLane(Z, 2, 512));
    addVec(0, Z, Z, Z);
    addVec(0, Z, Z, Z);
    for (int p = 1; p <= 2; p++) begin
      addVec(p, Z, Z, Z);
      addVec(p, setLane(Z, 0, 512), setLane(setLane(Z, 0, 256), 2, 256), setLane(setLane(Z, 1, 256), 3, 256));
      addVec(p, Z, Z, Z);
      addVec(p, Z, Z, Z);
    end
    addVec(3, Z, Z, Z);
    addVec(3, setLane(Z, 0, 512), setLane(setLane(Z, 0, 256), 2, 256),
           setLane(setLane(setLane(Z, 0, 64), 2, 128), 4, 64));
    addVec(3, Z, Z, Z);
    addVec(3, Z, Z, Z);
    for (int p = 4; p <= 5; p++) begin
      addVec(p, Z, Z, Z);
      addVec(p, setLane(Z, 0, 512), setLane(setLane(Z, 0, 256), 2, 256),
             setLane(setLane(setLane(Z, 0, 128), 2, 256), 4, 128));
      addVec(p, Z, Z, Z);
      addVec(p, Z, Z, Z);
    end
    addVec(6, Z, Z, Z);
    addVec(6, allLanes(2047), allLanes(2047), setLane(allLanes(2047), 0, 0));
    addVec(6, allLanes(2047), allLanes(2047), allLanes(2047));
    addVec(6, allLanes(-2048), setLane(allLanes(-2048), 0, 2046),
           setLane(setLane(allLanes(-2048), 0, 2047), 1, 2046));
    addVec(6, allLanes(-2048), allLanes(-2048), allLanes(-2048));
    addVec(6, Z, setLane(setLane(Z, 0, -2048), 1, -2048),
           setLane(setLane(setLane(Z, 0, -2048), 1, -2048), 2, -2048));
    addVec(6, Z, Z, Z);
    addVec(6, Z, Z, Z);

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("reset dat_o", dout, Z);
    checkOutput("reset probes", prb, Z);
    checkOutput("reset ack", 96'(ack), 96'd0);
    checkOutput("reset wb_dat_o", 96'(rdat), 96'd0);
    checkOutput("reset err rty", 96'({err, rty}), 96'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    $display("[TB] default one-sample delay in both stages");
    runPhase(0);

    $display("[TB] stage 0 B=0.5 A=0, reserved and unmapped writes ignored");
    wbWrite(8'h24, 32'h0001_2345);
    wbWrite(8'h04, 32'd8192);
    wbWrite(8'h08, 32'd12345);
    wbWrite(8'h04, 32'd0);
    wbWrite(8'h00, 32'd1);
    runPhase(1);

    $display("[TB] shadow writes to stage 1 stay invisible until update");
    wbWrite(8'h84, 32'd4096);
    wbWrite(8'h84, 32'd0);
    wbWrite(8'h80, 32'd2);
    runPhase(2);
    wbWrite(8'h80, 32'd1);
    runPhase(3);

    $display("[TB] cycle held open 5 clocks, strobe dropped on ack");
    @(posedge clk);
    #1;
    cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 8'h84; wdat = 32'd8192;
    pulses = 0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (ack) begin
        pulses++;
        stb = 1'b0;
        we = 1'b0;
      end
    end
    checkOutput("held request ack pulses", 96'(pulses), 96'd1);
    checkOutput("wb_dat_o zero", 96'(rdat), 96'd0);
    cyc = 1'b0;
    wbWrite(8'h80, 32'd1);
    runPhase(4);

    $display("[TB] filter clear held 32 clocks mid-stream");
    for (int k = 0; k < 4; k++) begin
      @(posedge clk);
      #1;
      din = allLanes(300);
    end
    rstBQ = 1'b1;
    for (int k = 0; k < 32; k++) begin
      @(posedge clk);
      #1;
      din = {$urandom, $urandom, $urandom};
      @(negedge clk);
      checkOutput($sformatf("clear dat_o c%0d", k), dout, Z);
      checkOutput($sformatf("clear probes c%0d", k), prb, Z);
    end
    rstBQ = 1'b0;
    din = '0;
    repeat (2) @(posedge clk);
    runPhase(5);

    $display("[TB] saturation with B=A=1.0 on stage 0");
    wbWrite(8'h04, 32'd16384);
    wbWrite(8'h04, 32'd16384);
    wbWrite(8'h00, 32'd1);
    wbWrite(8'h84, 32'd0);
    wbWrite(8'h84, 32'd16384);
    wbWrite(8'h80, 32'd1);
    runPhase(6);

    $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
    $finish;
  end

endmodule
